core_alu_reg: RTL and testbench
===============================

# core_alu_reg

8-bit arithmetic/logic unit with an optional registered output stage, used by the 2A03-style CPU core for all data-path arithmetic, logic, shift, compare and flag computation. The combinational ALU produces a result plus the N/V/Z/C flags under a per-flag update mask. A load-enabled register captures the result and flags so the core can latch them on its internal phase edge.

## Interface
- `RESET_VALUE`: default 8'h00; value loaded into the registered result on reset.
- `I_clock`: in, 1; single clock; all state updates on the rising edge.
- `I_reset`: in, 1; reset, synchronous and active-high.
- `I_enable`: in, 1; register load enable.
- `I_control`: in, 4; operation select, see Operation.
- `I_mask_p`: in, 4; flag update mask {N,V,Z,C}, bit3=N … bit0=C.
- `I_lhs`, `I_rhs`: in, 8 each; operands.
- `I_carry`, `I_overflow`, `I_sign`, `I_zero`: in, 1 each; current C, V, N, Z flags.
- `O_result`: out, 8; combinational result.
- `O_carry`, `O_overflow`, `O_sign`, `O_zero`: out, 1 each; combinational flags.
- `O_q_result`: out, 8; registered result.
- `O_q_flags`: out, 4; registered {N,V,Z,C}.

## Operation
Codes, with flags affected in brackets:
- 0 NOP: result=lhs [none]
- 1 ADC: lhs+rhs+C [NVZC]
- 2 SBC: lhs+~rhs+C [NVZC]
- 3 AND [NZ]
- 4 ORA [NZ]
- 5 EOR [NZ]
- 6 CMP: lhs−rhs, carry-in forced 1 [NZC]
- 7 ASL: C=lhs[7] [NZC]
- 8 LSR: C=lhs[0] [NZC]
- 9 ROL: {lhs[6:0],C} [NZC]
- 10 ROR: {C,lhs[7:1]} [NZC]
- 11 INC: lhs+1 [NZ]
- 12 DEC: lhs−1 [NZ]
- 13 BIT: result=lhs; Z=((lhs&rhs)==0), N=rhs[7], V=rhs[6] [NVZ]
- 14 LD: result=rhs [NZ]
- 15 ADD: lhs+rhs, no carry-in [C]; used for address indexing.

Rules:
- Binary arithmetic only; no decimal mode.
- Carry out is bit 8 of the 9-bit sum. For SBC/CMP, C=1 means no borrow.
- V = (lhs[7]==opnd[7]) && (res[7]!=lhs[7]), where opnd is rhs for ADC and ~rhs for SBC.
- N = result[7]; Z = (result==0). BIT is the exception, as defined above.
- A flag output takes its computed value only when the op affects that flag and the matching `I_mask_p` bit is 1. Otherwise it equals its input flag.
- INC/DEC wrap: 8'hFF+1 gives 8'h00; 8'h00−1 gives 8'hFF.

Register stage:
- `I_reset`=1: `O_q_result`=RESET_VALUE, `O_q_flags`=4'b0000.
- Otherwise, when `I_enable`=1: load `O_result` and {`O_sign`,`O_overflow`,`O_zero`,`O_carry`}.
- Otherwise: hold.
- Reset has priority over enable.

## Timing
- ALU path is purely combinational, zero latency.
- Registered outputs have 1-cycle latency after an enabled clock edge.
- Reset asserted with `I_enable` on the same edge: reset wins.
- Reset deasserted: the first enabled edge loads normally.

## Configuration
- `CORE_ALU_OUTPUT_REG_EN` defined: register stage present as described.
- Not defined: `O_q_result` and `O_q_flags` are driven directly from the combinational outputs. Clock, reset and enable are then ignored, and latency is zero.

## Test plan
- ADC lhs=0x50, rhs=0x50, C=0, mask=4'hF -> result 0xA0, N=1, V=1, Z=0, C=0.
- SBC lhs=0x00, rhs=0x01, C=1 -> 0xFF, C=0, N=1, Z=0, V=0; CMP 0x40 vs 0x40 -> Z=1, C=1, N=0, V passthrough.
- ROR lhs=0x01, C=1 -> 0x80, C=1, N=1; ASL 0x80 -> 0x00, C=1, Z=1.
- BIT lhs=0x0F, rhs=0xC0 -> Z=1, N=1, V=1, result 0x0F; ADC with mask=4'h0 -> all flags equal inputs.
- Register: reset -> q=RESET_VALUE/0; enable=1 with ADC 0x01+0x01 -> q_result=0x02 next cycle; enable=0 -> value held while inputs change.
- Reset and enable asserted together -> q=RESET_VALUE; INC 0xFF -> 0x00, Z=1.

Source files
------------

// File: rtl/core_alu_reg.sv
// core_alu_reg: 8-bit ALU (binary only) with N/V/Z/C flag generation under
// a per-flag update mask, plus an optional load-enabled output register.
// Define CORE_ALU_OUTPUT_REG_EN to include the register stage; otherwise the
// q outputs mirror the combinational outputs and clock/reset/enable are unused.
module core_alu_reg #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       I_clock,
  input  logic       I_reset,
  input  logic       I_enable,
  input  logic [3:0] I_control,
  input  logic [3:0] I_mask_p,
  input  logic [7:0] I_lhs,
  input  logic [7:0] I_rhs,
  input  logic       I_carry,
  input  logic       I_overflow,
  input  logic       I_sign,
  input  logic       I_zero,
  output logic [7:0] O_result,
  output logic       O_carry,
  output logic       O_overflow,
  output logic       O_sign,
  output logic       O_zero,
  output logic [7:0] O_q_result,
  output logic [3:0] O_q_flags
);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,  OP_ADC = 4'd1,  OP_SBC = 4'd2,  OP_AND = 4'd3,
    OP_ORA = 4'd4,  OP_EOR = 4'd5,  OP_CMP = 4'd6,  OP_ASL = 4'd7,
    OP_LSR = 4'd8,  OP_ROL = 4'd9,  OP_ROR = 4'd10, OP_INC = 4'd11,
    OP_DEC = 4'd12, OP_BIT = 4'd13, OP_LD  = 4'd14, OP_ADD = 4'd15
  } op_e;

  op_e        op;
  logic [7:0] opnd;
  logic       cin;
  logic [8:0] sum;
  logic [7:0] res;
  logic       n_calc, v_calc, z_calc, c_calc;
  logic [3:0] affects; // {N,V,Z,C}

  assign op = op_e'(I_control);

  // Shared adder operand/carry-in selection; INC/DEC reuse it with constants.
  always_comb begin
    opnd = I_rhs;
    cin  = I_carry;
    unique case (op)
      OP_SBC:  opnd = ~I_rhs;
      OP_CMP:  begin opnd = ~I_rhs; cin = 1'b1; end
      OP_INC:  begin opnd = 8'h00;  cin = 1'b1; end
      OP_DEC:  begin opnd = 8'hFF;  cin = 1'b0; end
      OP_ADD:  cin = 1'b0;
      default: ;
    endcase
  end

  assign sum = {1'b0, I_lhs} + {1'b0, opnd} + {8'h00, cin};

  // Result, raw flag values and the set of flags each op affects.
  always_comb begin
    res     = I_lhs;
    c_calc  = sum[8];
    v_calc  = (I_lhs[7] == opnd[7]) && (sum[7] != I_lhs[7]);
    affects = 4'b0000;
    unique case (op)
      OP_NOP: affects = 4'b0000;
      OP_ADC: begin res = sum[7:0]; affects = 4'b1111; end
      OP_SBC: begin res = sum[7:0]; affects = 4'b1111; end
      OP_AND: begin res = I_lhs & I_rhs; affects = 4'b1010; end
      OP_ORA: begin res = I_lhs | I_rhs; affects = 4'b1010; end
      OP_EOR: begin res = I_lhs ^ I_rhs; affects = 4'b1010; end
      OP_CMP: begin res = sum[7:0]; affects = 4'b1011; end
      OP_ASL: begin res = {I_lhs[6:0], 1'b0}; c_calc = I_lhs[7]; affects = 4'b1011; end
      OP_LSR: begin res = {1'b0, I_lhs[7:1]}; c_calc = I_lhs[0]; affects = 4'b1011; end
      OP_ROL: begin res = {I_lhs[6:0], I_carry}; c_calc = I_lhs[7]; affects = 4'b1011; end
      OP_ROR: begin res = {I_carry, I_lhs[7:1]}; c_calc = I_lhs[0]; affects = 4'b1011; end
      OP_INC: begin res = sum[7:0]; affects = 4'b1010; end
      OP_DEC: begin res = sum[7:0]; affects = 4'b1010; end
      OP_BIT: begin res = I_lhs; v_calc = I_rhs[6]; affects = 4'b1110; end
      OP_LD:  begin res = I_rhs; affects = 4'b1010; end
      OP_ADD: begin res = sum[7:0]; affects = 4'b0001; end
      default: ;
    endcase
    n_calc = (op == OP_BIT) ? I_rhs[7] : res[7];
    z_calc = (op == OP_BIT) ? ((I_lhs & I_rhs) == 8'h00) : (res == 8'h00);
  end

  // Flags take the computed value only when affected and unmasked.
  always_comb begin
    O_result   = res;
    O_sign     = (affects[3] && I_mask_p[3]) ? n_calc : I_sign;
    O_overflow = (affects[2] && I_mask_p[2]) ? v_calc : I_overflow;
    O_zero     = (affects[1] && I_mask_p[1]) ? z_calc : I_zero;
    O_carry    = (affects[0] && I_mask_p[0]) ? c_calc : I_carry;
  end

`ifdef CORE_ALU_OUTPUT_REG_EN
  // Output register: reset has priority over load enable.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      O_q_result <= RESET_VALUE;
      O_q_flags  <= '0;
    end else if (I_enable) begin
      O_q_result <= O_result;
      O_q_flags  <= {O_sign, O_overflow, O_zero, O_carry};
    end
  end
`else
  logic unused_reg_ctrl;
  assign unused_reg_ctrl = &{1'b0, I_clock, I_reset, I_enable};

  // Register stage absent: q outputs follow the combinational outputs.
  always_comb begin
    O_q_result = O_result;
    O_q_flags  = {O_sign, O_overflow, O_zero, O_carry};
  end
`endif

endmodule

// File: tb/tb_core_alu_reg.sv
// Directed-vector bench for core_alu_reg; expected values are hand-computed.
module tb_core_alu_reg;

  localparam logic [7:0] RV = 8'hA5;

  logic       I_clock = 1'b0;
  logic       I_reset = 1'b0;
  logic       I_enable = 1'b0;
  logic [3:0] I_control = '0;
  logic [3:0] I_mask_p = '0;
  logic [7:0] I_lhs = '0;
  logic [7:0] I_rhs = '0;
  logic       I_carry = 1'b0;
  logic       I_overflow = 1'b0;
  logic       I_sign = 1'b0;
  logic       I_zero = 1'b0;
  logic [7:0] O_result;
  logic       O_carry, O_overflow, O_sign, O_zero;
  logic [7:0] O_q_result;
  logic [3:0] O_q_flags;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  core_alu_reg #(.RESET_VALUE(RV)) dut (
    .I_clock(I_clock), .I_reset(I_reset), .I_enable(I_enable),
    .I_control(I_control), .I_mask_p(I_mask_p),
    .I_lhs(I_lhs), .I_rhs(I_rhs),
    .I_carry(I_carry), .I_overflow(I_overflow), .I_sign(I_sign), .I_zero(I_zero),
    .O_result(O_result), .O_carry(O_carry), .O_overflow(O_overflow),
    .O_sign(O_sign), .O_zero(O_zero),
    .O_q_result(O_q_result), .O_q_flags(O_q_flags)
  );

  always #5 I_clock = ~I_clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one ALU vector (input flags given as {N,V,Z,C}) and check outputs.
  task automatic alu_vec(input string tag, input logic [3:0] ctl, input logic [3:0] mask,
                         input logic [7:0] lhs, input logic [7:0] rhs, input logic [3:0] fin,
                         input logic [7:0] exp_res, input logic [3:0] exp_flags);
    I_control = ctl; I_mask_p = mask; I_lhs = lhs; I_rhs = rhs;
    {I_sign, I_overflow, I_zero, I_carry} = fin;
    #1;
    check({tag, ".res"}, O_result, exp_res);
    check({tag, ".flg"}, {4'h0, O_sign, O_overflow, O_zero, O_carry}, {4'h0, exp_flags});
`ifndef CORE_ALU_OUTPUT_REG_EN
    check({tag, ".qres"}, O_q_result, exp_res);
    check({tag, ".qflg"}, {4'h0, O_q_flags}, {4'h0, exp_flags});
`endif
  endtask

  initial begin
    @(negedge I_clock);
    //       tag     ctl    mask   lhs    rhs    fin      res    flags NVZC
    alu_vec("adc_v",  4'd1, 4'hF, 8'h50, 8'h50, 4'b0000, 8'hA0, 4'b1100);
    alu_vec("sbc_b",  4'd2, 4'hF, 8'h00, 8'h01, 4'b0101, 8'hFF, 4'b1000);
    alu_vec("cmp_eq", 4'd6, 4'hF, 8'h40, 8'h40, 4'b0100, 8'h00, 4'b0111);
    alu_vec("ror",   4'd10, 4'hF, 8'h01, 8'h00, 4'b0001, 8'h80, 4'b1001);
    alu_vec("asl",    4'd7, 4'hF, 8'h80, 8'h00, 4'b0000, 8'h00, 4'b0011);
    alu_vec("bit",   4'd13, 4'hF, 8'h0F, 8'hC0, 4'b0000, 8'h0F, 4'b1110);
    alu_vec("adc_m0", 4'd1, 4'h0, 8'h50, 8'h50, 4'b0110, 8'hA0, 4'b0110);
    alu_vec("adc_mN", 4'd1, 4'h8, 8'h50, 8'h50, 4'b0000, 8'hA0, 4'b1000);
    alu_vec("adc_c",  4'd1, 4'hF, 8'hFF, 8'h01, 4'b0001, 8'h01, 4'b0001);
    alu_vec("inc",   4'd11, 4'hF, 8'hFF, 8'h00, 4'b0101, 8'h00, 4'b0111);
    alu_vec("dec",   4'd12, 4'hF, 8'h00, 8'h00, 4'b0000, 8'hFF, 4'b1000);
    alu_vec("lsr",    4'd8, 4'hF, 8'h81, 8'h00, 4'b0000, 8'h40, 4'b0001);
    alu_vec("rol",    4'd9, 4'hF, 8'h80, 8'h00, 4'b0001, 8'h01, 4'b0001);
    alu_vec("and",    4'd3, 4'hF, 8'hF0, 8'h3C, 4'b0000, 8'h30, 4'b0000);
    alu_vec("ora",    4'd4, 4'hF, 8'h00, 8'h00, 4'b0000, 8'h00, 4'b0010);
    alu_vec("eor",    4'd5, 4'hF, 8'hFF, 8'h0F, 4'b0000, 8'hF0, 4'b1000);
    alu_vec("ld",    4'd14, 4'hF, 8'h12, 8'h80, 4'b0010, 8'h80, 4'b1000);
    alu_vec("add",   4'd15, 4'hF, 8'hFF, 8'h01, 4'b1000, 8'h00, 4'b1001);
    alu_vec("nop",    4'd0, 4'hF, 8'h5A, 8'h33, 4'b1010, 8'h5A, 4'b1010);

`ifdef CORE_ALU_OUTPUT_REG_EN
    // Reset
    I_reset = 1'b1; I_enable = 1'b0;
    @(posedge I_clock); #1;
    check("rst.q", O_q_result, RV);
    check("rst.f", {4'h0, O_q_flags}, 8'h00);
    // Enabled load: ADC 01+01
    @(negedge I_clock);
    I_reset = 1'b0; I_enable = 1'b1;
    I_control = 4'd1; I_mask_p = 4'hF; I_lhs = 8'h01; I_rhs = 8'h01;
    {I_sign, I_overflow, I_zero, I_carry} = 4'b0000;
    @(posedge I_clock); #1;
    check("ld.q", O_q_result, 8'h02);
    check("ld.f", {4'h0, O_q_flags}, 8'h00);
    // Hold while inputs change
    @(negedge I_clock);
    I_enable = 1'b0; I_control = 4'd14; I_rhs = 8'h80;
    @(posedge I_clock); #1;
    check("hold.q", O_q_result, 8'h02);
    check("hold.f", {4'h0, O_q_flags}, 8'h00);
    // Load LD 0x80 -> N set
    @(negedge I_clock);
    I_enable = 1'b1;
    @(posedge I_clock); #1;
    check("ld2.q", O_q_result, 8'h80);
    check("ld2.f", {4'h0, O_q_flags}, 8'h08);
    // Reset and enable together: reset wins
    @(negedge I_clock);
    I_reset = 1'b1;
    @(posedge I_clock); #1;
    check("rstpri.q", O_q_result, RV);
    check("rstpri.f", {4'h0, O_q_flags}, 8'h00);
    // First enabled edge after reset release loads normally
    @(negedge I_clock);
    I_reset = 1'b0; I_control = 4'd11; I_lhs = 8'hFF;
    @(posedge I_clock); #1;
    check("post.q", O_q_result, 8'h00);
    check("post.f", {4'h0, O_q_flags}, 8'h02);
`else
    // Without the register stage, clock/reset/enable have no effect.
    @(negedge I_clock);
    I_reset = 1'b1; I_enable = 1'b1;
    I_control = 4'd11; I_mask_p = 4'hF; I_lhs = 8'hFF;
    {I_sign, I_overflow, I_zero, I_carry} = 4'b0000;
    @(posedge I_clock); #1;
    check("bypass.q", O_q_result, 8'h00);
    check("bypass.f", {4'h0, O_q_flags}, 8'h02);
    @(negedge I_clock);
    I_reset = 1'b0; I_enable = 1'b0; I_control = 4'd14; I_rhs = 8'h80;
    #1;
    check("bypass2.q", O_q_result, 8'h80);
    check("bypass2.f", {4'h0, O_q_flags}, 8'h08);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
